// File: rtl/imem_loader.sv
// UART program loader: receives an 8N1 byte stream, assembles little-endian words,
// writes a length-prefixed image into imem and releases the processor once it is complete.
module imem_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned WORD         = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    output logic        mem_we,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [31:0] MAX_WORDS = 32'(WORD);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_LEN, LD_DATA, LD_DONE, LD_ERR} ld_state_t;

    logic            rx_s1;
    logic            rx_s2;
    rx_state_t       rx_state;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            byte_stb;
    logic            frame_err;

    logic [1:0]      byte_cnt;
    logic [23:0]     word_buf;
    logic            word_stb_c;
    logic [31:0]     word_c;

    ld_state_t       ld_state;
    logic [31:0]     len;
    logic [31:0]     index;

    // Two-flop synchronizer for the asynchronous RX pin
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
        end
    end

    // UART receiver; STOP returns to IDLE mid stop bit so a back-to-back start is caught
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s2) begin
                        rx_state <= RX_START;
                        timer    <= '0;
                    end
                end
                RX_START: begin
                    if (timer == HALF_BIT) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (timer == LAST_TICK) begin
                        timer <= '0;
                        shift <= {rx_s2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer == LAST_TICK) begin
                        timer    <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            byte_stb <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Little-endian word assembly; the fourth byte completes the word in the same cycle
    assign word_stb_c = byte_stb && (byte_cnt == 2'd3);
    assign word_c     = {shift, word_buf};

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            word_buf <= '0;
        end else if (byte_stb) begin
            byte_cnt <= byte_cnt + 1'b1;
            case (byte_cnt)
                2'd0:    word_buf[7:0]   <= shift;
                2'd1:    word_buf[15:8]  <= shift;
                2'd2:    word_buf[23:16] <= shift;
                default: word_buf        <= word_buf;
            endcase
        end
    end

    // Loader: length word, then N data words written at consecutive indices
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state <= LD_LEN;
            len      <= '0;
            index    <= '0;
            mem_addr <= '0;
            mem_in   <= '0;
            mem_we   <= 1'b0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            cpu_rst <= !done;
            case (ld_state)
                LD_LEN: begin
                    if (frame_err) begin
                        ld_state <= LD_ERR;
                        err      <= 1'b1;
                    end else if (word_stb_c) begin
                        if (word_c == 32'd0) begin
                            ld_state <= LD_DONE;
                            done     <= 1'b1;
                        end else if (word_c > MAX_WORDS) begin
                            ld_state <= LD_ERR;
                            err      <= 1'b1;
                        end else begin
                            ld_state <= LD_DATA;
                            len      <= word_c;
                            index    <= '0;
                        end
                    end
                end
                LD_DATA: begin
                    if (frame_err) begin
                        ld_state <= LD_ERR;
                        err      <= 1'b1;
                    end else if (word_stb_c) begin
                        mem_we   <= 1'b1;
                        mem_addr <= index;
                        mem_in   <= word_c;
                        index    <= index + 32'd1;
                        if (index == len - 32'd1) begin
                            ld_state <= LD_DONE;
                            done     <= 1'b1;
                        end
                    end
                end
                LD_DONE: ld_state <= LD_DONE;
                LD_ERR:  ld_state <= LD_ERR;
                default: ld_state <= LD_ERR;
            endcase
        end
    end

endmodule
